// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accounting, slot selection, stepper
// start/finish handshake with start timeout, and refunds.
module vend_ctrl #(
    parameter logic [7:0]  PRICE        = 8'd100,
    parameter logic [7:0]  COIN_VALUE   = 8'd25,
    parameter logic [7:0]  CREDIT_MAX   = 8'd200,
    parameter logic [31:0] VEND_TIMEOUT = 32'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_pulse,
    input  logic [3:0] sel_pulse,
    input  logic       refund_pulse,
    input  logic [3:0] motor_busy,
    output logic [3:0] vend_pulse,
    output logic [7:0] credit,
    output logic       refund_valid,
    output logic [7:0] refund_amount,
    output logic       coin_reject,
    output logic       deny,
    output logic       fault,
    output logic       busy
);

    localparam int unsigned CREDIT_W = 8;
    localparam int unsigned SUM_W    = CREDIT_W + 1;
    localparam int unsigned SLOT_W   = 2;
    localparam int unsigned TMO_W    = 32;

    localparam logic [1:0] IDLE            = 2'd0;
    localparam logic [1:0] VEND_WAIT_START = 2'd1;
    localparam logic [1:0] VEND_WAIT_DONE  = 2'd2;

    logic [1:0]          state, state_nxt;
    logic [SLOT_W-1:0]   slot, slot_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;

    logic [3:0]          vend_pulse_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                refund_valid_nxt;
    logic [CREDIT_W-1:0] refund_amount_nxt;
    logic                coin_reject_nxt;
    logic                deny_nxt;
    logic                fault_nxt;
    logic                busy_nxt;

    logic                sel_any;
    logic [SLOT_W-1:0]   sel_idx;
    logic                take_refund;
    logic [SUM_W-1:0]    coin_base;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_ok;
    logic [SUM_W-1:0]    credit_acc;
    logic [SUM_W-1:0]    restore_sum;

    // Lowest set select bit wins
    always_comb begin
        sel_idx = SLOT_W'(0);
        casez (sel_pulse)
            4'b???1: sel_idx = SLOT_W'(0);
            4'b??10: sel_idx = SLOT_W'(1);
            4'b?100: sel_idx = SLOT_W'(2);
            4'b1000: sel_idx = SLOT_W'(3);
            default: sel_idx = SLOT_W'(0);
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt         = state;
        slot_nxt          = slot;
        tmo_cnt_nxt       = tmo_cnt;
        vend_pulse_nxt    = 4'b0000;
        refund_valid_nxt  = 1'b0;
        refund_amount_nxt = refund_amount;
        coin_reject_nxt   = 1'b0;
        deny_nxt          = 1'b0;
        fault_nxt         = fault;
        restore_sum       = '0;

        sel_any     = |sel_pulse;
        // A select in the same idle cycle drops the refund request
        take_refund = (state == IDLE) && refund_pulse && !sel_any && (credit != '0);

        // A same-cycle refund empties credit before the coin is added
        coin_base       = take_refund ? '0 : {1'b0, credit};
        coin_sum        = coin_base + {1'b0, COIN_VALUE};
        coin_ok         = coin_pulse && (coin_sum <= {1'b0, CREDIT_MAX});
        coin_reject_nxt = coin_pulse && !coin_ok;
        credit_acc      = coin_ok ? coin_sum : coin_base;

        case (state)
            IDLE: begin
                if (sel_any) begin
                    if ({1'b0, credit} >= {1'b0, PRICE}) begin
                        vend_pulse_nxt = 4'b0001 << sel_idx;
                        credit_acc     = credit_acc - {1'b0, PRICE};
                        slot_nxt       = sel_idx;
                        tmo_cnt_nxt    = '0;
                        state_nxt      = VEND_WAIT_START;
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end else if (take_refund) begin
                    refund_valid_nxt  = 1'b1;
                    refund_amount_nxt = credit;
                end
            end
            VEND_WAIT_START: begin
                if (motor_busy[slot]) begin
                    state_nxt = VEND_WAIT_DONE;
                end else if (tmo_cnt == VEND_TIMEOUT) begin
                    // Motor never started: give the price back, capped at the ceiling
                    restore_sum = credit_acc + {1'b0, PRICE};
                    credit_acc  = (restore_sum > {1'b0, CREDIT_MAX}) ? {1'b0, CREDIT_MAX}
                                                                     : restore_sum;
                    fault_nxt   = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            VEND_WAIT_DONE: begin
                if (!motor_busy[slot]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        credit_nxt = credit_acc[CREDIT_W-1:0];
        busy_nxt   = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            slot          <= '0;
            tmo_cnt       <= '0;
            vend_pulse    <= 4'b0000;
            credit        <= '0;
            refund_valid  <= 1'b0;
            refund_amount <= '0;
            coin_reject   <= 1'b0;
            deny          <= 1'b0;
            fault         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            slot          <= slot_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            vend_pulse    <= vend_pulse_nxt;
            credit        <= credit_nxt;
            refund_valid  <= refund_valid_nxt;
            refund_amount <= refund_amount_nxt;
            coin_reject   <= coin_reject_nxt;
            deny          <= deny_nxt;
            fault         <= fault_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with a shortened start timeout.
module tb_vend_ctrl;

    localparam logic [31:0] TMO = 32'd20;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_pulse;
    logic [3:0] sel_pulse;
    logic       refund_pulse;
    logic [3:0] motor_busy;
    logic [3:0] vend_pulse;
    logic [7:0] credit;
    logic       refund_valid;
    logic [7:0] refund_amount;
    logic       coin_reject;
    logic       deny;
    logic       fault;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_wait;

    vend_ctrl #(
        .PRICE        (8'd100),
        .COIN_VALUE   (8'd25),
        .CREDIT_MAX   (8'd200),
        .VEND_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_pulse    (coin_pulse),
        .sel_pulse     (sel_pulse),
        .refund_pulse  (refund_pulse),
        .motor_busy    (motor_busy),
        .vend_pulse    (vend_pulse),
        .credit        (credit),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .coin_reject   (coin_reject),
        .deny          (deny),
        .fault         (fault),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic coin, input logic [3:0] sel, input logic refund);
        coin_pulse   = coin;
        sel_pulse    = sel;
        refund_pulse = refund;
        step();
        coin_pulse   = 1'b0;
        sel_pulse    = 4'b0000;
        refund_pulse = 1'b0;
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 4'b0000, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        coin_pulse   = 1'b0;
        sel_pulse    = 4'b0000;
        refund_pulse = 1'b0;
        motor_busy   = 4'b0000;
        step();
        step();
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_vend", vend_pulse, 0);
        check("rst_ramt", refund_amount, 0);
        rst = 1'b0;

        // Refund with zero credit does nothing
        pulse(1'b0, 4'b0000, 1'b1);
        check("refund0_valid", refund_valid, 0);

        // Four coins and a vend on slot 1
        coins(4);
        check("a_credit100", credit, 100);
        pulse(1'b0, 4'b0010, 1'b0);
        check("a_vend", vend_pulse, 4'b0010);
        check("a_credit0", credit, 0);
        check("a_busy", busy, 1);
        step();
        check("a_vend_off", vend_pulse, 0);
        check("a_busy_start", busy, 1);
        motor_busy = 4'b0010;
        step();
        check("a_busy_done", busy, 1);
        pulse(1'b0, 4'b0001, 1'b0);
        check("a_ign_deny", deny, 0);
        check("a_ign_vend", vend_pulse, 0);
        motor_busy = 4'b0000;
        step();
        check("a_idle", busy, 0);

        // Insufficient credit is denied
        coins(3);
        pulse(1'b0, 4'b0001, 1'b0);
        check("b_deny", deny, 1);
        check("b_vend", vend_pulse, 0);
        check("b_credit", credit, 75);
        step();
        check("b_deny_off", deny, 0);
        pulse(1'b0, 4'b0000, 1'b1);
        check("b_rvalid", refund_valid, 1);
        check("b_ramt", refund_amount, 75);
        check("b_credit0", credit, 0);
        step();
        check("b_rvalid_off", refund_valid, 0);
        check("b_ramt_hold", refund_amount, 75);

        // Credit ceiling
        coins(8);
        check("c_credit200", credit, 200);
        check("c_noreject", coin_reject, 0);
        coins(1);
        check("c_reject", coin_reject, 1);
        check("c_credit_hold", credit, 200);
        step();
        check("c_reject_off", coin_reject, 0);
        pulse(1'b0, 4'b0000, 1'b1);
        check("c_ramt", refund_amount, 200);

        // Timeout on slot 2 restores credit and sets fault
        coins(5);
        check("d_credit125", credit, 125);
        pulse(1'b0, 4'b1100, 1'b0);
        check("d_vend", vend_pulse, 4'b0100);
        check("d_credit25", credit, 25);
        n_wait = 0;
        while (busy && n_wait < 200) begin
            step();
            n_wait++;
        end
        check("d_wait_cycles", n_wait, TMO + 1);
        check("d_credit_back", credit, 125);
        check("d_fault", fault, 1);
        check("d_busy", busy, 0);
        pulse(1'b0, 4'b0000, 1'b1);
        check("d_ramt", refund_amount, 125);

        // Refund and coin in the same cycle
        coins(2);
        pulse(1'b1, 4'b0000, 1'b1);
        check("e_rvalid", refund_valid, 1);
        check("e_ramt", refund_amount, 50);
        check("e_credit", credit, 25);
        step();
        check("e_rvalid_off", refund_valid, 0);

        // Coin and accepted select in the same cycle
        coins(3);
        pulse(1'b1, 4'b0001, 1'b0);
        check("f_vend", vend_pulse, 4'b0001);
        check("f_credit", credit, 25);
        motor_busy = 4'b0001;
        step();
        motor_busy = 4'b0000;
        step();
        check("f_idle", busy, 0);

        // Select beats refund; then reset while the motor runs
        coins(3);
        pulse(1'b0, 4'b1000, 1'b1);
        check("g_vend", vend_pulse, 4'b1000);
        check("g_norefund", refund_valid, 0);
        check("g_credit", credit, 0);
        motor_busy = 4'b1000;
        step();
        check("g_busy", busy, 1);
        check("g_fault_sticky", fault, 1);
        rst = 1'b1;
        step();
        check("h_credit", credit, 0);
        check("h_busy", busy, 0);
        check("h_fault", fault, 0);
        check("h_ramt", refund_amount, 0);
        check("h_vend", vend_pulse, 0);
        check("h_pulses", {refund_valid, coin_reject, deny}, 0);
        rst = 1'b0;
        motor_busy = 4'b0000;
        step();
        check("h_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
